regfile_access_ctrl: RTL

Controller in front of the 32×32 integer register file. Sequences a post-reset clear of every register. Owns the single write port, sharing it between pipeline writeback and a debug requester. Steals read port 1 for debug reads, requesting a one-cycle pipeline stall. Sits between the WB stage, the debug interface and the register file instance.

---
 rtl/regfile_ctrl_pkg.sv | 19 +
 rtl/regfile_access_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared definitions for the register file access controller: FSM state
// encoding, the hardwired-zero register index and default geometry.
package regfile_ctrl_pkg;

  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = 5;
  localparam int DW_DEF    = 32;

  // Index of the hardwired-zero register; writes to it are dropped.
  localparam int REG_ZERO  = 0;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_DBG_RD = 2'd2,
    ST_RSP    = 2'd3
  } state_e;

endpackage

// File: rtl/regfile_access_ctrl.sv
// Register file access controller.
// - Clears every register after reset (optional), one register per cycle.
// - Owns the single write port: writeback has priority over debug writes.
// - Borrows read port 1 for one cycle on a debug read and stalls the pipe.
//
// Debug handshake: a request transfers on a rising edge where
// dbg_req_valid and dbg_req_ready are both high. The requester holds
// valid and its payload stable until that edge. The response is a
// single-cycle dbg_rsp_valid pulse with dbg_rsp_data (0 for write acks).
module regfile_access_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int NREGS          = NREGS_DEF,
  parameter int AW             = AW_DEF,
  parameter int DW             = DW_DEF,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  input  logic          dbg_req_valid,
  output logic          dbg_req_ready,
  input  logic          dbg_req_write,
  input  logic [AW-1:0] dbg_req_addr,
  input  logic [DW-1:0] dbg_req_wdata,
  output logic          dbg_rsp_valid,
  output logic [DW-1:0] dbg_rsp_data,
  output logic          stall_req,
  output logic          init_done,
  output logic          rf_we,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd,
  output logic          rf_ra_sel,
  output logic [AW-1:0] rf_ra,
  input  logic [DW-1:0] rf_rd,
  output logic [1:0]    state_dbg
);

  localparam logic [1:0] S_INIT   = ST_INIT;
  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_DBG_RD = ST_DBG_RD;
  localparam logic [1:0] S_RSP    = ST_RSP;

  localparam logic [1:0]    RST_STATE = CLEAR_ON_RESET ? S_INIT : S_IDLE;
  localparam logic [AW-1:0] LAST_REG  = AW'(NREGS - 1);
  localparam logic [AW-1:0] ZERO_REG  = AW'(REG_ZERO);

  logic [1:0]    state;
  logic [AW-1:0] clr_cnt;
  logic          wb_hit;
  logic          dbg_accept;
  logic          dbg_wr_hit;

  // A writeback to x0 is not a real write and does not occupy the port.
  assign wb_hit     = wb_we && (wb_rd != ZERO_REG);

  // Only IDLE accepts requests; a debug write yields to a real writeback.
  assign dbg_req_ready = !rst && (state == S_IDLE) &&
                         (!dbg_req_write || !wb_hit);
  assign dbg_accept = dbg_req_valid && dbg_req_ready;
  assign dbg_wr_hit = dbg_accept && dbg_req_write && (dbg_req_addr != ZERO_REG);

  assign stall_req  = (state == S_INIT) || (state == S_DBG_RD);
  assign rf_ra_sel  = (state == S_DBG_RD);
  assign state_dbg  = state;

  // Write port mux: clear sweep during INIT, otherwise writeback then debug.
  always_comb begin
    rf_we = 1'b0;
    rf_wa = '0;
    rf_wd = '0;
    if (!rst) begin
      if (state == S_INIT) begin
        rf_we = 1'b1;
        rf_wa = clr_cnt;
      end else if (wb_hit) begin
        rf_we = 1'b1;
        rf_wa = wb_rd;
        rf_wd = wb_data;
      end else if (dbg_wr_hit) begin
        rf_we = 1'b1;
        rf_wa = dbg_req_addr;
        rf_wd = dbg_req_wdata;
      end
    end
  end

  // Controller FSM, clear counter and registered debug response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RST_STATE;
      clr_cnt       <= '0;
      init_done     <= !CLEAR_ON_RESET;
      rf_ra         <= '0;
      dbg_rsp_valid <= 1'b0;
      dbg_rsp_data  <= '0;
    end else begin
      dbg_rsp_valid <= 1'b0;
      case (state)
        S_INIT: begin
          if (clr_cnt == LAST_REG) begin
            clr_cnt   <= '0;
            init_done <= 1'b1;
            state     <= S_IDLE;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (dbg_accept) begin
            if (dbg_req_write) begin
              dbg_rsp_valid <= 1'b1;
              dbg_rsp_data  <= '0;
              state         <= S_RSP;
            end else begin
              rf_ra <= dbg_req_addr;
              state <= S_DBG_RD;
            end
          end
        end
        S_DBG_RD: begin
          // Captures the pre-edge contents; a same-edge write is not seen.
          dbg_rsp_valid <= 1'b1;
          dbg_rsp_data  <= rf_rd;
          state         <= S_RSP;
        end
        S_RSP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= RST_STATE;
        end
      endcase
    end
  end

endmodule
